// File: rtl/paralelo_serial_pkg.sv
// rtl/paralelo_serial_pkg.sv - shared PHY constants and link state encoding
package paralelo_serial_pkg;

  localparam logic [7:0] DEF_COMMA       = 8'hBC;
  localparam int         DEF_PREAMBLE_BC = 4;

  typedef enum logic {
    PREAMBLE = 1'b0,
    ACTIVE   = 1'b1
  } link_state_t;

endpackage

// File: rtl/paralelo_serial_piso.sv
// rtl/paralelo_serial_piso.sv - 8-bit parallel-in serial-out shifter, MSB first
module piso_shifter8 #(
  parameter logic [7:0] INIT = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       serial_out,
  output logic       last_bit
);

  logic [7:0] shift_q;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      shift_q <= INIT;
      bit_cnt <= 3'd0;
    end else if (load) begin
      shift_q <= byte_in;
      bit_cnt <= 3'd0;
    end else begin
      shift_q <= {shift_q[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign serial_out = shift_q[7];
  assign last_bit   = (bit_cnt == 3'd7);

endmodule

// File: rtl/paralelo_serial.sv
// rtl/paralelo_serial.sv - byte serializer with comma preamble and one-byte holding register
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter logic [7:0] COMMA       = DEF_COMMA,
  parameter int         PREAMBLE_BC = DEF_PREAMBLE_BC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);

  localparam int CW = (PREAMBLE_BC < 2) ? 1 : $clog2(PREAMBLE_BC + 1);

  link_state_t state;
  logic [CW-1:0] pre_cnt;
  logic [7:0] hold;
  logic       full;
  logic       last_bit;
  logic       data_slot;
  logic       accept;
  logic [7:0] next_byte;

  // The load edge that completes the preamble already picks up held data.
  assign data_slot = (state == ACTIVE) || (pre_cnt == CW'(PREAMBLE_BC - 1));
  assign next_byte = (data_slot && full) ? hold : COMMA;
  assign accept    = valid_in && !full;
  assign ready_out = !full;

  piso_shifter8 #(.INIT(COMMA)) u_piso (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .load       (last_bit),
    .byte_in    (next_byte),
    .serial_out (data_out),
    .last_bit   (last_bit)
  );

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state      <= PREAMBLE;
      active_out <= 1'b0;
      pre_cnt    <= '0;
      hold       <= 8'h00;
      full       <= 1'b0;
    end else begin
      if (last_bit && state == PREAMBLE) begin
        pre_cnt <= pre_cnt + CW'(1);
        if (data_slot) begin
          state      <= ACTIVE;
          active_out <= 1'b1;
        end
      end
      // accept requires !full, so it never collides with draining the register
      if (accept) begin
        hold <= data_in;
        full <= 1'b1;
      end else if (last_bit && data_slot && full) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// tb/tb_paralelo_serial.sv - randomized self-checking bench against a byte-schedule model
module tb_paralelo_serial;
  import paralelo_serial_pkg::*;

  localparam int PB = DEF_PREAMBLE_BC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       active_out;

  paralelo_serial dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .active_out (active_out)
  );

  always #5 clk_32f = ~clk_32f;

  int n_cmp = 0;
  int n_bad = 0;

  // model: cycle index since reset release, byte on the wire, holding slot
  int         m_cyc;
  logic [7:0] m_byte;
  logic       m_held;
  logic [7:0] m_hold;
  logic       m_acc;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, m_cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    m_byte = DEF_COMMA;
    m_held = 1'b0;
    m_hold = 8'h00;
  endtask

  task automatic one_cycle(input logic v, input logic [7:0] d);
    logic [7:0] nb;
    int bitpos;
    bitpos = 7 - (m_cyc % 8);
    expect_eq("data_out", {31'd0, data_out}, {31'd0, m_byte[bitpos]});
    expect_eq("ready_out", {31'd0, ready_out}, {31'd0, !m_held});
    expect_eq("active_out", {31'd0, active_out}, {31'd0, m_cyc >= 8 * PB});
    valid_in = v;
    data_in  = d;
    @(posedge clk_32f);
    m_acc = v && !m_held;
    if (m_cyc % 8 == 7) begin
      nb = DEF_COMMA;
      if ((m_cyc / 8 + 1) >= PB && m_held) begin
        nb     = m_hold;
        m_held = 1'b0;
      end
      m_byte = nb;
    end
    if (m_acc) begin
      m_held = 1'b1;
      m_hold = d;
    end
    m_cyc++;
    @(negedge clk_32f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) one_cycle(1'b0, $urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    m_acc = 1'b0;
    while (!m_acc && k < 20) begin
      one_cycle(1'b1, b);
      k++;
    end
    expect_eq("accept_bound", {31'd0, m_acc}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    expect_eq("rst_data_out", {31'd0, data_out}, 32'd1);
    expect_eq("rst_ready", {31'd0, ready_out}, 32'd1);
    expect_eq("rst_active", {31'd0, active_out}, 32'd0);

    // A5 offered during preamble, sent as the first data byte
    idle(5);
    one_cycle(1'b1, 8'hA5);
    idle(64 - m_cyc);

    // back-to-back bytes with valid held
    send_byte(8'h3C);
    send_byte(8'hFF);
    send_byte(8'h00);
    idle(24);

    // byte offered exactly on a load edge with the register empty
    while (m_cyc % 8 != 7 || m_held) one_cycle(1'b0, 8'h00);
    one_cycle(1'b1, 8'h81);
    idle(16);

    for (int i = 0; i < 300; i++) one_cycle(($urandom % 3) == 0, $urandom);
    for (int i = 0; i < 100; i++) one_cycle(1'b1, $urandom);

    // reset mid-byte while a byte is held
    send_byte(8'h5A);
    send_byte(8'hC3);
    idle(2);
    expect_eq("held_before_rst", {31'd0, m_held}, 32'd1);
    #2 reset = 1'b1;
    #1;
    expect_eq("async_data_out", {31'd0, data_out}, 32'd1);
    expect_eq("async_active", {31'd0, active_out}, 32'd0);
    expect_eq("async_ready", {31'd0, ready_out}, 32'd1);
    do_reset();
    idle(40);
    for (int i = 0; i < 200; i++) one_cycle(($urandom % 2) == 0, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paralelo_serial.md
PARALELO_SERIAL -- requirements
Module: paralelo_serial

Interface
REQ-001 Parameter: COMMA, 8'hBC, idle/alignment symbol sent when no data is pending.
REQ-002 Parameter: PREAMBLE_BC, 4, number of COMMA bytes sent after reset before data may be serialized.
REQ-003 Port: clk_32f  input  1  bit clock; every register samples on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: data_in  input  8  parallel byte to transmit.
REQ-006 Port: valid_in  input  1  data_in holds a byte to transmit.
REQ-007 Port: ready_out  output  1  holding register empty; a byte is accepted on an edge where valid_in & ready_out.
REQ-008 Port: data_out  output  1  serial bit stream, MSB of each byte first.
REQ-009 Port: active_out  output  1  preamble complete; link carrying data/idle.

Function
REQ-010 The block SHALL contain an 8-bit shift register, a 3-bit bit counter, a 1-byte holding register with full flag, a preamble byte counter and a 2-state FSM {PREAMBLE, ACTIVE}.
REQ-011 data_out SHALL equal shift register bit 7 directly, with no extra register stage.
REQ-012 Each edge SHALL shift the shift register left by one and increment the bit counter, except on the load edge.
REQ-013 Load edge SHALL be the edge where bit counter == 7: reload the shift register with the next byte and set the bit counter to 0.
REQ-014 Byte k after reset release SHALL therefore occupy data_out during cycles 8k..8k+7.
REQ-015 In PREAMBLE, the next byte SHALL be COMMA.
REQ-016 The preamble counter SHALL count completed bytes, including the reset-loaded comma.
REQ-017 When PREAMBLE_BC bytes have completed, the FSM SHALL enter ACTIVE at that load edge and set active_out=1, so byte PREAMBLE_BC is the first byte that can carry data.
REQ-018 In ACTIVE, the next byte SHALL be the holding register contents if it is full, and the full flag SHALL clear on that same edge; otherwise the next byte SHALL be COMMA.
REQ-019 ACTIVE SHALL be left only by reset.
REQ-020 ready_out SHALL be the inverse of the holding full flag (combinational).
REQ-021 An accepted byte SHALL be captured into the holding register and set full; acceptance is allowed in both states.
REQ-022 There SHALL be no bypass: a byte accepted on a load edge with the register empty is NOT sent at that edge, and COMMA is sent instead (in ACTIVE).
REQ-023 Accept and load on the same edge cannot conflict: ready_out is low whenever the register is full.
REQ-024 A data byte equal to COMMA SHALL be transmitted unchanged; the far-end receiver treats it as idle (valid low), and the user is responsible for avoiding it.
REQ-025 Throughput SHALL be at most one byte per 8 cycles.
REQ-026 Latency from acceptance to the first serialized bit SHALL be 1 to 8 cycles, set by the next load edge.
REQ-027 When valid_in is low, the holding register SHALL be unchanged and data_in is ignored.

Reset
REQ-028 On reset assertion, independent of clk_32f: shift register=COMMA (so data_out=1), bit counter=0, preamble counter=0, hold=8'h00, full=0 (ready_out=1), FSM=PREAMBLE, active_out=0.
REQ-029 Reset asserted mid-byte or mid-operation SHALL abort the byte in flight, discard any held byte, and restart the full preamble after release.

Structure
REQ-030 COMMA, PREAMBLE_BC default and the FSM state encoding SHALL live in the shared PHY package, for use by both the receive and transmit paths.
REQ-031 The shift register with its bit counter SHALL be a sub-module named piso_shifter8 (load, byte in, serial out, last-bit flag); the FSM and holding register stay in the top module.

Verification
REQ-032 Reset release, valid_in=0, 64 cycles -> data_out repeats 10111100 eight times; active_out rises at the edge ending cycle 31.
REQ-033 Present 8'hA5 at cycle 5 -> accepted immediately; cycles 32-39 carry 10100101; ready_out returns high at the edge ending cycle 31.
REQ-034 In ACTIVE, present 8'h3C, 8'hFF, 8'h00 back-to-back with valid_in held -> three consecutive bytes with no COMMA between them; ready_out low while full.
REQ-035 Accept 8'h81 exactly on a load edge with the register empty -> that byte is COMMA; 8'h81 is sent on the following byte.
REQ-036 Assert reset at cycle 45 mid-byte while a byte is held -> data_out=1 immediately, active_out=0; after release the full 4-comma preamble repeats and the held byte is never sent.
REQ-037 Loopback into the existing serial_paralelo deserializer with bytes 01..10 -> deserializer outputs 01..10 in order with valid high, and idles with valid low.
